// File: rtl/quokka_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quokka_input_pkg
// Description : Shared types, constants and helpers for the quokka input
//               conditioner. Provides the debounce counter width helper, the
//               debounce count type and the default synchroniser depth.
// Revision    : 1.0 - initial release
// ============================================================================
package quokka_input_pkg;

  // Debounce cycle count as seen by the channel parameters
  typedef int unsigned debounceCount_t;

  // Default number of synchroniser flops per channel
  localparam int c_defaultSyncStages = 2;

  // Counter width for a given debounce length. A zero-length filter has no
  // counter; we still return 1 so that any declared vector stays legal.
  function automatic int cntWidth(input int debounceCycles);
    if (debounceCycles < 1) begin
      return 1;
    end
    return $clog2(debounceCycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/quokka_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : quokka_input_conditioner_if
// Description : Signal bundle between board pins / user logic and the input
//               conditioner.
//   Enable  : 1 = filter may update Out, 0 = Out frozen
//   In      : raw asynchronous inputs (WIDTH)
//   Out     : synchronised, debounced levels (WIDTH)
//   Rise    : one-cycle pulse on Out 0->1 (WIDTH)
//   Fall    : one-cycle pulse on Out 1->0 (WIDTH)
//   Changed : OR of all Rise|Fall bits
//   master  : drives Enable/In, observes outputs
//   slave   : the conditioner itself
// Revision    : 1.0 - initial release
// ============================================================================
interface quokka_input_conditioner_if #(
  parameter int WIDTH = 4
);
  logic             Enable;
  logic [WIDTH-1:0] In;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] Rise;
  logic [WIDTH-1:0] Fall;
  logic             Changed;

  modport master (
    output Enable,
    output In,
    input  Out,
    input  Rise,
    input  Fall,
    input  Changed
  );

  modport slave (
    input  Enable,
    input  In,
    output Out,
    output Rise,
    output Fall,
    output Changed
  );
endinterface
`default_nettype wire

// File: rtl/quokka_input_channel.sv
`default_nettype none
// ============================================================================
// Module      : quokka_input_channel
// Description : Single-bit input conditioning path: SYNC_STAGES-deep
//               synchroniser, consecutive-cycle debounce filter and optional
//               registered edge pulses.
//   Clock  : system clock, posedge
//   Reset  : asynchronous active-low reset
//   Enable : 1 = filter may update Out
//   In     : raw asynchronous input bit
//   Out    : debounced level
//   Rise   : one-cycle pulse when Out goes 0->1
//   Fall   : one-cycle pulse when Out goes 1->0
// Config      : QUOKKA_INPUT_EDGE_EN builds the edge registers; otherwise
//               Rise/Fall are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module quokka_input_channel
  import quokka_input_pkg::*;
#(
  parameter int             SYNC_STAGES     = c_defaultSyncStages,
  parameter debounceCount_t DEBOUNCE_CYCLES = 16,
  parameter logic           RESET_VALUE     = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic In,
  output logic Out,
  output logic Rise,
  output logic Fall
);

  logic [SYNC_STAGES-1:0] r_syncChain;
  logic                   w_syncOut;
  logic                   w_nextOut;
  logic                   r_out;

  // Synchroniser runs every edge regardless of Enable so that a re-enable
  // sees an already-settled level.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_syncChain <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], In};
    end
  end

  assign w_syncOut = r_syncChain[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb begin
        w_nextOut = r_out;
        if (Enable) begin
          w_nextOut = w_syncOut;
        end
      end
    end else begin : g_debounce
      localparam int                c_cntW    = cntWidth(DEBOUNCE_CYCLES);
      localparam logic [c_cntW-1:0] c_cntLast = c_cntW'(DEBOUNCE_CYCLES - 1);

      logic [c_cntW-1:0] r_count;
      logic [c_cntW-1:0] w_nextCount;

      // Any cycle where the synchronised level matches Out (or the filter
      // is disabled) restarts the count; the last mismatching cycle commits.
      always_comb begin
        w_nextCount = '0;
        w_nextOut   = r_out;
        if (Enable && (w_syncOut != r_out)) begin
          if (r_count == c_cntLast) begin
            w_nextOut = w_syncOut;
          end else begin
            w_nextCount = r_count + 1'b1;
          end
        end
      end

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          r_count <= '0;
        end else begin
          r_count <= w_nextCount;
        end
      end
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_out <= RESET_VALUE;
    end else begin
      r_out <= w_nextOut;
    end
  end

  assign Out = r_out;

`ifdef QUOKKA_INPUT_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses load on the same edge as Out, so they line up with the first
  // cycle the new level is visible. Disabled filter keeps w_nextOut == r_out.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_nextOut & ~r_out;
      r_fall <= ~w_nextOut & r_out;
    end
  end

  assign Rise = r_rise;
  assign Fall = r_fall;
`else
  assign Rise = 1'b0;
  assign Fall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/quokka_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : quokka_input_conditioner
// Description : Multi-channel conditioner for asynchronous board inputs.
//               Instantiates one quokka_input_channel per bit and ORs the
//               edge pulses into Changed.
//   Clock : system clock, posedge
//   Reset : asynchronous active-low reset
//   bus   : quokka_input_conditioner_if.slave (Enable, In, Out, Rise, Fall,
//           Changed)
// Config      : QUOKKA_INPUT_EDGE_EN enables Rise/Fall/Changed; when
//               undefined they are constant 0 but the ports remain.
// Revision    : 1.0 - initial release
// ============================================================================
module quokka_input_conditioner
  import quokka_input_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = c_defaultSyncStages,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic                        Clock,
  input  logic                        Reset,
  quokka_input_conditioner_if.slave   bus
);

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_channel
      quokka_input_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (RESET_VALUE[i])
      ) u_channel (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (bus.Enable),
        .In     (bus.In[i]),
        .Out    (w_out[i]),
        .Rise   (w_rise[i]),
        .Fall   (w_fall[i])
      );
    end
  endgenerate

  assign bus.Out  = w_out;
  assign bus.Rise = w_rise;
  assign bus.Fall = w_fall;

`ifdef QUOKKA_INPUT_EDGE_EN
  assign bus.Changed = |(w_rise | w_fall);
`else
  assign bus.Changed = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quokka_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_quokka_input_conditioner
// Description : Directed self-checking bench. dut uses DEBOUNCE_CYCLES=4,
//               dutB uses DEBOUNCE_CYCLES=0 (filter bypassed). Edge pulse
//               expectations follow QUOKKA_INPUT_EDGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quokka_input_conditioner;

`ifdef QUOKKA_INPUT_EDGE_EN
  localparam bit c_edgeEn = 1'b1;
`else
  localparam bit c_edgeEn = 1'b0;
`endif

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  quokka_input_conditioner_if #(.WIDTH(4)) busA ();
  quokka_input_conditioner_if #(.WIDTH(4)) busB ();

  quokka_input_conditioner #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'h0)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (busA)
  );

  quokka_input_conditioner #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .RESET_VALUE(4'h0)
  ) dutB (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (busB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  function automatic logic [3:0] pulse(input bit hit, input logic [3:0] val);
    return (c_edgeEn && hit) ? val : 4'h0;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b0;
    busA.Enable = 1'b0;
    busA.In     = 4'hF;
    busB.Enable = 1'b0;
    busB.In     = 4'h0;

    // Reset state with inputs high and clock running
    step(3);
    check("rst_out",     busA.Out,     4'h0);
    check("rst_rise",    busA.Rise,    4'h0);
    check("rst_fall",    busA.Fall,    4'h0);
    check("rst_changed", busA.Changed, 1'b0);
    check("rst_outB",    busB.Out,     4'h0);

    // Release; first sampling edge is c=1, Out updates at c=6
    Reset = 1'b1;
    busA.Enable = 1'b1;
    busB.Enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      check("t1_out",     busA.Out,     (c >= 6) ? 4'hF : 4'h0);
      check("t1_rise",    busA.Rise,    pulse(c == 6, 4'hF));
      check("t1_fall",    busA.Fall,    4'h0);
      check("t1_changed", busA.Changed, pulse(c == 6, 4'h1));
    end

    // All channels back to 0, single Fall pulse
    busA.In = 4'h0;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      check("fall_out",  busA.Out,  (c >= 6) ? 4'h0 : 4'hF);
      check("fall_fall", busA.Fall, pulse(c == 6, 4'hF));
      check("fall_rise", busA.Rise, 4'h0);
    end

    // 3-cycle glitch on In[0] is rejected
    busA.In = 4'h1;
    for (int c = 1; c <= 11; c++) begin
      step(1);
      check("t2_out",  busA.Out,  4'h0);
      check("t2_rise", busA.Rise, 4'h0);
      if (c == 3) busA.In = 4'h0;
    end

    // In[1] toggles 1,0,1,0 then holds 1
    busA.In = 4'h2; step(1); check("t3_tog_out", busA.Out, 4'h0);
    busA.In = 4'h0; step(1); check("t3_tog_out", busA.Out, 4'h0);
    busA.In = 4'h2; step(1); check("t3_tog_out", busA.Out, 4'h0);
    busA.In = 4'h0; step(1); check("t3_tog_out", busA.Out, 4'h0);
    busA.In = 4'h2;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      check("t3_out",  busA.Out,  (c >= 6) ? 4'h2 : 4'h0);
      check("t3_rise", busA.Rise, pulse(c == 6, 4'h2));
    end

    busA.In = 4'h0;
    step(8);
    check("t3_clear", busA.Out, 4'h0);

    // Disabled: Out frozen while sync chain settles on 4'hA
    busA.Enable = 1'b0;
    busA.In     = 4'hA;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      check("t4_dis_out",  busA.Out,  4'h0);
      check("t4_dis_rise", busA.Rise, 4'h0);
      check("t4_dis_fall", busA.Fall, 4'h0);
    end
    busA.Enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step(1);
      check("t4_out",  busA.Out,  (c >= 4) ? 4'hA : 4'h0);
      check("t4_rise", busA.Rise, pulse(c == 4, 4'hA));
      check("t4_fall", busA.Fall, 4'h0);
    end

    // Asynchronous reset mid-count
    busA.In = 4'hF;
    step(8);
    check("t5_pre_out", busA.Out, 4'hF);
    busA.In = 4'h0;
    step(4);
    check("t5_cnt2",    dut.g_channel[0].u_channel.g_debounce.r_count, 3'd2);
    check("t5_hold",    busA.Out, 4'hF);
    #2;
    Reset = 1'b0;
    #1;
    check("t5_out",     busA.Out,     4'h0);
    check("t5_rise",    busA.Rise,    4'h0);
    check("t5_fall",    busA.Fall,    4'h0);
    check("t5_changed", busA.Changed, 1'b0);
    check("t5_cnt0",    dut.g_channel[0].u_channel.g_debounce.r_count, 3'd0);
    step(1);
    check("t5_out_held", busA.Out, 4'h0);
    Reset = 1'b1;

    // Bypassed filter: Out registers the synchronised level (c=3)
    busB.In = 4'h5;
    for (int c = 1; c <= 5; c++) begin
      step(1);
      check("t6_out",     busB.Out,     (c >= 3) ? 4'h5 : 4'h0);
      check("t6_rise",    busB.Rise,    pulse(c == 3, 4'h5));
      check("t6_fall",    busB.Fall,    4'h0);
      check("t6_changed", busB.Changed, pulse(c == 3, 4'h1));
    end
    busB.In = 4'hA;
    for (int c = 1; c <= 5; c++) begin
      step(1);
      check("t6b_out",     busB.Out,     (c >= 3) ? 4'hA : 4'h5);
      check("t6b_rise",    busB.Rise,    pulse(c == 3, 4'hA));
      check("t6b_fall",    busB.Fall,    pulse(c == 3, 4'h5));
      check("t6b_changed", busB.Changed, pulse(c == 3, 4'h1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quokka_input_conditioner.md
Name: quokka_input_conditioner

Overview:
Parametrised multi-channel input conditioner for asynchronous board inputs (buttons, switches, external strobes).
- Per channel: N-stage metastability synchroniser, then a consecutive-cycle debounce filter, then optional single-cycle edge pulses.
- Sits between top-level pins and user logic; Enable is normally driven from BoardSignals_Started so outputs stay quiet during startup.

Parameters:
WIDTH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 16, consecutive mismatching cycles needed to accept a new level; 0 = filter bypassed
RESET_VALUE, 0, WIDTH-bit reset level for sync chain and Out

Ports:
Clock  in  1  single system clock, all flops posedge
Reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to Clock at the instantiating level
Enable  in  1  1 = filter may update Out; 0 = Out frozen
In  in  WIDTH  raw asynchronous inputs
Out  out  WIDTH  synchronised, debounced levels
Rise  out  WIDTH  one-cycle pulse when Out[i] goes 0->1
Fall  out  WIDTH  one-cycle pulse when Out[i] goes 1->0
Changed  out  1  OR-reduction of Rise|Fall

Behaviour:
- Reset (Reset=0, asynchronous):
  - sync chain and Out = RESET_VALUE.
  - All debounce counters = 0.
  - Rise = Fall = Changed = 0.
  - Applies without a clock edge, including mid-count.
- Synchroniser:
  - Per-channel shift register of SYNC_STAGES flops; shifts every edge regardless of Enable.
  - s[i] = last stage.
- Debounce counter:
  - Per channel, width CNT_W = $clog2(DEBOUNCE_CYCLES+1).
  - Each edge with Enable=1:
    - if s[i]==Out[i]: cnt<=0
    - else if cnt==DEBOUNCE_CYCLES-1: Out[i]<=s[i], cnt<=0
    - else: cnt<=cnt+1
  - A new level must mismatch for DEBOUNCE_CYCLES consecutive edges; any single-cycle return to Out[i] restarts the count.
  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Bypass: DEBOUNCE_CYCLES=1 gives one extra register. DEBOUNCE_CYCLES=0 means no counter; Out[i] is registered from s[i] each enabled edge.
- Latency: an input level stable from sampling edge k appears on Out at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (DEBOUNCE_CYCLES>=1).
- Enable=0:
  - counters held at 0, Out held, Rise/Fall forced 0 next edge.
  - Sync chain continues running.
  - On re-enable, counting restarts from 0.
- Edge pulses:
  - Registered on the same edge Out[i] updates, so Rise[i] is high exactly during the first cycle Out[i] shows the new value.
  - Rise[i] and Fall[i] are mutually exclusive.
  - Pulses never last more than one cycle, since Out[i] cannot change on consecutive edges when DEBOUNCE_CYCLES>=2.
- Channels are fully independent; simultaneous updates on multiple channels are permitted.

Optional Feature:
QUOKKA_INPUT_EDGE_EN
- Defined: Rise/Fall/Changed behave as above.
- Undefined: edge registers are not built; Rise, Fall, Changed are tied to constant 0. Ports remain present so the port list is unchanged.

Decomposition:
- Package quokka_input_pkg:
  - function clog2-based CNT_W helper
  - typedef debounce count type
  - constant default SYNC_STAGES=2
- One sub-module, quokka_input_channel: single-bit sync chain, counter and edge logic.
- Top-level generate-loops it WIDTH times and ORs Changed.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0, macro defined unless noted):
1. Reset=0 with In=4'hF, then release, Enable=1, hold In=4'hF -> Out=0 during reset; Out=4'hF at 5th edge after first sampling edge; Rise=4'hF and Changed=1 for exactly one cycle.
2. In[0] high for 3 cycles then low -> Out[0] stays 0, Rise[0] never asserts.
3. In[1] toggles 1,0,1,0,1 on consecutive edges, then holds 1 -> Out[1] rises 5 edges after the final sampled 1; single Rise[1] pulse.
4. Enable=0, In=4'hA held 10 cycles -> Out unchanged, no pulses. Then Enable=1 -> Out=4'hA after 4 edges; Rise=4'hA, Fall=0.
5. Out=4'hF, In=0, assert Reset between edges when counter=2 -> Out=0, counters=0, pulses=0 immediately, with no Clock edge.
6. Build without QUOKKA_INPUT_EDGE_EN, with DEBOUNCE_CYCLES=0 -> Out follows In 2 edges later; Rise/Fall/Changed constant 0 throughout.
